xs3_bcd_decoder: RTL

XS3_BCD_DECODER -- requirements
Module: xs3_bcd_decoder

---
 rtl/xs3_bcd_decoder.sv | 90 +++++++++
 1 files changed

// File: rtl/xs3_bcd_decoder.sv
// Excess-3 to BCD frame decoder: collects NDIG excess-3 digits (MSD first),
// decodes each to BCD, and presents the packed frame with a sticky error flag
// under a valid/ready handshake on both sides.
module xs3_bcd_decoder #(
    parameter int unsigned NDIG = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [3:0]          in_code,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*NDIG-1:0]   out_bcd,
    output logic                out_err,
    output logic [3:0]          dig_cnt
);

    localparam int unsigned W    = 4 * NDIG;
    localparam logic [3:0]  LAST = 4'(NDIG - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   bcd_next;
    logic           err_next;
    logic [3:0]     cnt_next;
    logic           legal;
    logic [3:0]     digit;

    // Next-state and datapath update: shift in decoded digits while collecting,
    // release the frame on the output handshake while holding.
    always_comb begin
        state_next = state;
        bcd_next   = out_bcd;
        err_next   = out_err;
        cnt_next   = dig_cnt;
        legal      = (in_code >= 4'd3) && (in_code <= 4'd12);
        digit      = legal ? (in_code - 4'd3) : 4'd0;

        case (state)
            COLLECT: begin
                if (in_valid) begin
                    bcd_next = {out_bcd[W-5:0], digit};
                    err_next = out_err | ~legal;
                    cnt_next = dig_cnt + 4'd1;
                    if (dig_cnt == LAST) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                // out_bcd is intentionally kept; the next frame overwrites it
                if (out_ready) begin
                    state_next = COLLECT;
                    cnt_next   = 4'd0;
                    err_next   = 1'b0;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    // State and output registers; handshake flags follow the next state so
    // they stay free of any combinational input path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            out_bcd   <= '0;
            out_err   <= 1'b0;
            dig_cnt   <= 4'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            out_bcd   <= bcd_next;
            out_err   <= err_next;
            dig_cnt   <= cnt_next;
            in_ready  <= (state_next == COLLECT);
            out_valid <= (state_next == HOLD);
        end
    end

endmodule
